tinyalu_cmd_sequencer: RTL and testbench
========================================

Name: tinyalu_cmd_sequencer

Overview:
Synthesizable command front-end that sits directly upstream of the TinyALU DUT.
- Accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command with the TinyALU start/done protocol, including reset and no-op commands.
- Returns each completed result, tagged with its op, on a valid/ready response stream.
- Replaces the testbench's send_op sequencing with RTL, for emulation and system-level use.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)
MAX_WAIT, 31, cycles of start-high without done before a command is abandoned as a timeout

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept; equals !full
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_op  input  3  operation_t encoding: no_op=000, add=001, and=010, xor=011, mul=100, rst_op=111
alu_a  output  8  operand to ALU
alu_b  output  8  operand to ALU
alu_op  output  3  op to ALU
alu_start  output  1  ALU start
alu_reset_n  output  1  ALU active-low reset
alu_done  input  1  ALU done
alu_result  input  16  ALU result
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  16  captured result, 0 on timeout or error
rsp_op  output  3  op of the completed command
rsp_status  output  2  00 ok, 01 timeout, 10 illegal op
busy  output  1  FSM not in IDLE, or FIFO not empty

Behaviour:
Reset (reset=1 at posedge):
- FIFO emptied; FSM goes to IDLE; timeout counter cleared.
- alu_start=0, alu_a=0, alu_b=0, alu_op=000.
- alu_reset_n=0 while reset is high, then 1.
- rsp_valid=0, rsp_result=0, rsp_op=000, rsp_status=00, busy=0.
- Reset mid-command abandons the command silently; no response is produced.

FIFO:
- Push when cmd_valid && cmd_ready. cmd_ready=0 when full, with no same-cycle pop bypass.
- Push and pop in the same cycle are both honoured.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

FSM states: IDLE, RUN, NOP, RST1, RST2, RESP.
IDLE:
- If FIFO not empty, pop the head and register alu_a/alu_b/alu_op from it.
- add/and/xor/mul: go to RUN with alu_start=1 from the next cycle; timeout counter=0.
- no_op: go to NOP with alu_start=1.
- rst_op: go to RST1 with alu_reset_n=0 and alu_start=0.
- 101/110 (illegal): load response with status 10 and result 0; go to RESP. No ALU activity.
RUN:
- Each cycle, alu_start stays 1 and the counter increments.
- alu_done=1 sampled: capture alu_result, alu_start<=0, status 00, go to RESP.
- Counter==MAX_WAIT with no done: alu_start<=0, result 0, status 01, go to RESP.
- done on the same cycle the counter reaches MAX_WAIT counts as ok.
NOP:
- alu_start is high for exactly one cycle, then goes low.
- Return to IDLE; no response is produced.
RST1 -> RST2:
- alu_reset_n held 0 for two cycles, then 1.
- Return to IDLE; no response is produced.
RESP:
- rsp_valid=1; response fields held stable while rsp_ready=0.
- On rsp_valid && rsp_ready, rsp_valid<=0 and go to IDLE.
- Earliest next issue is the following cycle, so back-to-back commands have at least 1 idle cycle between start pulses.

Latency: a command present in the FIFO sees alu_start rise 1 cycle after the pop, and rsp_valid rises the cycle after done is sampled.
Commands are strictly in order. At most one command is outstanding at the ALU.

Decomposition:
- tinyalu_pkg: reuse operation_t and add:
  - status_t (OK, TIMEOUT, ILLEGAL)
  - the seq_state_t enum
  - cmd_entry_s {A, B, op}
  - constant ILLEGAL_OPS
- Sub-module tinyalu_cmd_fifo:
  - parameterized sync FIFO of cmd_entry_s, with full/empty/count.
  - The FSM, counter and response register live in tinyalu_cmd_sequencer.

Test Plan:
1. Push add A=8'hFF, B=8'h01; ALU raises done after 1 cycle with result 16'h0100 -> alu_start high exactly until done; rsp_result=16'h0100, rsp_op=001, rsp_status=00.
2. Push mul 8'hFF×8'hFF, then xor 8'hAA^8'h55, with done delayed 3 cycles for mul -> in-order responses 16'hFE01 then 16'h00FF; at least one idle cycle between start pulses.
3. Fill 4 commands while rsp_ready=0 -> cmd_ready=0 at count 4; the 5th push is refused; first response held stable; after rsp_ready=1, all 4 responses drain in order.
4. Push rst_op then no_op -> alu_reset_n low for exactly 2 cycles; alu_start high for 1 cycle; no rsp_valid for either.
5. Push add with alu_done tied 0 -> rsp_valid after MAX_WAIT (31) start cycles with rsp_status=01 and rsp_result=0; push op=101 -> rsp_status=10 with no alu_start pulse.
6. Assert reset for 1 cycle while in RUN with 2 entries queued -> all outputs return to reset values; FIFO empty; no response is ever produced for the abandoned commands.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - shared types and constants for the TinyALU command sequencer
package tinyalu_pkg;

   typedef enum logic [2:0] {
      NO_OP  = 3'b000,
      ADD_OP = 3'b001,
      AND_OP = 3'b010,
      XOR_OP = 3'b011,
      MUL_OP = 3'b100,
      RST_OP = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_TIMEOUT = 2'b01,
      ST_ILLEGAL = 2'b10
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_NOP,
      S_RST1,
      S_RST2,
      S_RESP
   } seq_state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
   } cmd_entry_s;

   // One bit per 3-bit op code; set bits are encodings the ALU does not implement.
   localparam logic [7:0] ILLEGAL_OPS = 8'b0110_0000;

   function automatic logic is_illegal_op(input logic [2:0] op);
      return ILLEGAL_OPS[op];
   endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// rtl/tinyalu_cmd_fifo.sv - synchronous command FIFO with full/empty/count
module tinyalu_cmd_fifo
   import tinyalu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  cmd_entry_s               i_data,
   input  logic                     i_pop,
   output cmd_entry_s               o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   cmd_entry_s        r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   // No pop bypass when full: a full FIFO refuses even if a pop happens this cycle.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tinyalu_cmd_sequencer.sv
// rtl/tinyalu_cmd_sequencer.sv - queues ALU commands and drives the TinyALU start/done handshake
module tinyalu_cmd_sequencer
   import tinyalu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_WAIT   = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [2:0]  cmd_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_start,
   output logic        alu_reset_n,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [2:0]  rsp_op,
   output logic [1:0]  rsp_status,
   output logic        busy
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   seq_state_t   r_state,       w_state_nxt;
   logic [CW-1:0] r_cnt,        w_cnt_nxt;
   logic         r_alu_start,   w_alu_start_nxt;
   logic         r_alu_reset_n, w_alu_reset_n_nxt;
   logic [7:0]   r_alu_a,       w_alu_a_nxt;
   logic [7:0]   r_alu_b,       w_alu_b_nxt;
   logic [2:0]   r_alu_op,      w_alu_op_nxt;
   logic         r_rsp_valid,   w_rsp_valid_nxt;
   logic [15:0]  r_rsp_result,  w_rsp_result_nxt;
   logic [2:0]   r_rsp_op,      w_rsp_op_nxt;
   status_t      r_rsp_status,  w_rsp_status_nxt;

   cmd_entry_s   w_cmd;
   cmd_entry_s   w_head;
   logic         w_full;
   logic         w_empty;
   logic         w_pop;
   logic [$clog2(FIFO_DEPTH):0] w_count;

   assign w_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op};

   tinyalu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (cmd_valid),
      .i_data  (w_cmd),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_state_nxt       = r_state;
      w_pop             = 1'b0;
      w_cnt_nxt         = r_cnt;
      w_alu_start_nxt   = r_alu_start;
      w_alu_reset_n_nxt = r_alu_reset_n;
      w_alu_a_nxt       = r_alu_a;
      w_alu_b_nxt       = r_alu_b;
      w_alu_op_nxt      = r_alu_op;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_result_nxt  = r_rsp_result;
      w_rsp_op_nxt      = r_rsp_op;
      w_rsp_status_nxt  = r_rsp_status;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_alu_a_nxt  = w_head.a;
               w_alu_b_nxt  = w_head.b;
               w_alu_op_nxt = w_head.op;
               w_cnt_nxt    = '0;
               if (is_illegal_op(w_head.op)) begin
                  w_rsp_valid_nxt  = 1'b1;
                  w_rsp_result_nxt = '0;
                  w_rsp_op_nxt     = w_head.op;
                  w_rsp_status_nxt = ST_ILLEGAL;
                  w_state_nxt      = S_RESP;
               end else if (w_head.op == NO_OP) begin
                  w_alu_start_nxt = 1'b1;
                  w_state_nxt     = S_NOP;
               end else if (w_head.op == RST_OP) begin
                  w_alu_start_nxt   = 1'b0;
                  w_alu_reset_n_nxt = 1'b0;
                  w_state_nxt       = S_RST1;
               end else begin
                  w_alu_start_nxt = 1'b1;
                  w_state_nxt     = S_RUN;
               end
            end
         end
         S_RUN: begin
            // The counter value MAX_WAIT-1 marks the last start-high cycle, so
            // done arriving in that cycle still wins over the timeout.
            w_cnt_nxt = r_cnt + 1'b1;
            if (alu_done) begin
               w_alu_start_nxt  = 1'b0;
               w_rsp_valid_nxt  = 1'b1;
               w_rsp_result_nxt = alu_result;
               w_rsp_op_nxt     = r_alu_op;
               w_rsp_status_nxt = ST_OK;
               w_state_nxt      = S_RESP;
            end else if (r_cnt == CW'(MAX_WAIT - 1)) begin
               w_alu_start_nxt  = 1'b0;
               w_rsp_valid_nxt  = 1'b1;
               w_rsp_result_nxt = '0;
               w_rsp_op_nxt     = r_alu_op;
               w_rsp_status_nxt = ST_TIMEOUT;
               w_state_nxt      = S_RESP;
            end
         end
         S_NOP: begin
            w_alu_start_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
         end
         S_RST1: begin
            w_state_nxt = S_RST2;
         end
         S_RST2: begin
            w_alu_reset_n_nxt = 1'b1;
            w_state_nxt       = S_IDLE;
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_alu_start   <= 1'b0;
         r_alu_reset_n <= 1'b1;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_op      <= '0;
         r_rsp_status  <= ST_OK;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_alu_start   <= w_alu_start_nxt;
         r_alu_reset_n <= w_alu_reset_n_nxt;
         r_alu_a       <= w_alu_a_nxt;
         r_alu_b       <= w_alu_b_nxt;
         r_alu_op      <= w_alu_op_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_result  <= w_rsp_result_nxt;
         r_rsp_op      <= w_rsp_op_nxt;
         r_rsp_status  <= w_rsp_status_nxt;
      end
   end

   // The ALU is held in reset combinationally for as long as our own reset is high.
   assign alu_reset_n = !reset && r_alu_reset_n;
   assign alu_start   = r_alu_start;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign cmd_ready   = !w_full;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_result  = r_rsp_result;
   assign rsp_op      = r_rsp_op;
   assign rsp_status  = r_rsp_status;
   assign busy        = (r_state != S_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
// tb/tb_tinyalu_cmd_sequencer.sv - directed self-checking bench for tinyalu_cmd_sequencer
module tb_tinyalu_cmd_sequencer;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_reset_n;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic [1:0]  rsp_status;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   tinyalu_cmd_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_op      (cmd_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_start   (alu_start),
      .alu_reset_n (alu_reset_n),
      .alu_done    (alu_done),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_op      (rsp_op),
      .rsp_status  (rsp_status),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag, output int n);
      n = 0;
      while (!alu_start && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_start_seen"}, {31'd0, alu_start}, 32'd1);
   endtask

   task automatic issue_and_done(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input int delay, input logic [15:0] result);
      int n;
      wait_start(tag, n);
      chk({tag, "_alu_a"}, {24'd0, alu_a}, {24'd0, a});
      chk({tag, "_alu_b"}, {24'd0, alu_b}, {24'd0, b});
      chk({tag, "_alu_op"}, {29'd0, alu_op}, {29'd0, op});
      for (int i = 1; i < delay; i++) begin
         tick();
         chk({tag, "_start_held"}, {31'd0, alu_start}, 32'd1);
      end
      alu_done   = 1'b1;
      alu_result = result;
      tick();
      alu_done   = 1'b0;
      alu_result = 16'h0;
      chk({tag, "_start_fall"}, {31'd0, alu_start}, 32'd0);
   endtask

   task automatic expect_rsp(input string tag, input logic [15:0] result, input logic [2:0] op,
                             input logic [1:0] status);
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_rsp_result"}, {16'd0, rsp_result}, {16'd0, result});
      chk({tag, "_rsp_op"}, {29'd0, rsp_op}, {29'd0, op});
      chk({tag, "_rsp_status"}, {30'd0, rsp_status}, {30'd0, status});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_alu_start"}, {31'd0, alu_start}, 32'd0);
      chk({tag, "_alu_a"}, {24'd0, alu_a}, 32'd0);
      chk({tag, "_alu_b"}, {24'd0, alu_b}, 32'd0);
      chk({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
      chk({tag, "_alu_reset_n"}, {31'd0, alu_reset_n}, 32'd0);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_result"}, {16'd0, rsp_result}, 32'd0);
      chk({tag, "_rsp_op"}, {29'd0, rsp_op}, 32'd0);
      chk({tag, "_rsp_status"}, {30'd0, rsp_status}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
   endtask

   initial begin
      int n;
      int starts;
      int lows;
      int rsps;

      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_a      = 8'h0;
      cmd_b      = 8'h0;
      cmd_op     = 3'b000;
      alu_done   = 1'b0;
      alu_result = 16'h0;
      rsp_ready  = 1'b1;
      @(negedge clk);
      tick();
      tick();
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick();
      chk("post_reset_alu_reset_n", {31'd0, alu_reset_n}, 32'd1);
      chk("post_reset_busy", {31'd0, busy}, 32'd0);

      // Test 1: add FF+01, done one cycle after start
      push("t1_push", 8'hFF, 8'h01, 3'b001);
      issue_and_done("t1", 8'hFF, 8'h01, 3'b001, 1, 16'h0100);
      expect_rsp("t1", 16'h0100, 3'b001, 2'b00);
      tick();
      chk("t1_rsp_consumed", {31'd0, rsp_valid}, 32'd0);
      chk("t1_idle_busy", {31'd0, busy}, 32'd0);

      // Test 2: mul then xor, in order, with a gap between start pulses
      push("t2_push_mul", 8'hFF, 8'hFF, 3'b100);
      push("t2_push_xor", 8'hAA, 8'h55, 3'b011);
      issue_and_done("t2_mul", 8'hFF, 8'hFF, 3'b100, 3, 16'hFE01);
      expect_rsp("t2_mul", 16'hFE01, 3'b100, 2'b00);
      wait_start("t2_gap", n);
      chk("t2_idle_gap", {31'd0, n >= 1}, 32'd1);
      issue_and_done("t2_xor", 8'hAA, 8'h55, 3'b011, 1, 16'h00FF);
      expect_rsp("t2_xor", 16'h00FF, 3'b011, 2'b00);
      tick();

      // Test 3: response back-pressure, FIFO fills and refuses the fifth push
      rsp_ready = 1'b0;
      push("t3_push0", 8'h01, 8'h02, 3'b001);
      issue_and_done("t3_c0", 8'h01, 8'h02, 3'b001, 1, 16'h0003);
      expect_rsp("t3_c0", 16'h0003, 3'b001, 2'b00);
      push("t3_push1", 8'h0F, 8'h3C, 3'b010);
      push("t3_push2", 8'hF0, 8'h0F, 3'b011);
      push("t3_push3", 8'h80, 8'h80, 3'b001);
      push("t3_push4", 8'h0C, 8'h0D, 3'b100);
      chk("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
      chk("t3_full_busy", {31'd0, busy}, 32'd1);
      cmd_valid = 1'b1;
      cmd_a     = 8'h02;
      cmd_b     = 8'h02;
      cmd_op    = 3'b100;
      tick();
      cmd_valid = 1'b0;
      chk("t3_still_full", {31'd0, cmd_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("t3_hold_result", {16'd0, rsp_result}, 32'h0003);
         chk("t3_hold_no_start", {31'd0, alu_start}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      issue_and_done("t3_c1", 8'h0F, 8'h3C, 3'b010, 2, 16'h000C);
      expect_rsp("t3_c1", 16'h000C, 3'b010, 2'b00);
      issue_and_done("t3_c2", 8'hF0, 8'h0F, 3'b011, 1, 16'h00FF);
      expect_rsp("t3_c2", 16'h00FF, 3'b011, 2'b00);
      issue_and_done("t3_c3", 8'h80, 8'h80, 3'b001, 1, 16'h0100);
      expect_rsp("t3_c3", 16'h0100, 3'b001, 2'b00);
      issue_and_done("t3_c4", 8'h0C, 8'h0D, 3'b100, 4, 16'h009C);
      expect_rsp("t3_c4", 16'h009C, 3'b100, 2'b00);
      starts = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (alu_start) starts++;
      end
      chk("t3_refused_never_issued", starts, 0);
      chk("t3_drained_busy", {31'd0, busy}, 32'd0);

      // Test 4: rst_op then no_op
      cmd_valid = 1'b1;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_op    = 3'b111;
      tick();
      cmd_op    = 3'b000;
      lows   = 0;
      starts = 0;
      rsps   = 0;
      for (int i = 0; i < 12; i++) begin
         if (!alu_reset_n) lows++;
         if (alu_start) starts++;
         if (rsp_valid) rsps++;
         tick();
         if (i == 0) cmd_valid = 1'b0;
      end
      chk("t4_reset_n_low_cycles", lows, 2);
      chk("t4_nop_start_cycles", starts, 1);
      chk("t4_no_response", rsps, 0);
      chk("t4_busy", {31'd0, busy}, 32'd0);

      // Test 5a: done never arrives, timeout after MAX_WAIT start cycles
      push("t5_push_to", 8'h12, 8'h34, 3'b001);
      starts = 0;
      for (int i = 0; i < 60 && !rsp_valid; i++) begin
         if (alu_start) starts++;
         tick();
      end
      chk("t5_timeout_start_cycles", starts, 31);
      expect_rsp("t5_timeout", 16'h0000, 3'b001, 2'b01);
      tick();

      // Test 5b: done on the very last start cycle still counts as ok
      push("t5_push_edge", 8'h05, 8'h06, 3'b001);
      issue_and_done("t5_edge", 8'h05, 8'h06, 3'b001, 31, 16'h000B);
      expect_rsp("t5_edge", 16'h000B, 3'b001, 2'b00);
      tick();

      // Test 5c: illegal op 101 yields status 10 without any start pulse
      push("t5_push_ill", 8'h11, 8'h22, 3'b101);
      starts = 0;
      for (int i = 0; i < 10 && !rsp_valid; i++) begin
         if (alu_start) starts++;
         tick();
      end
      chk("t5_illegal_no_start", starts, 0);
      expect_rsp("t5_illegal", 16'h0000, 3'b101, 2'b10);
      tick();

      // Test 6: reset while RUN with two entries queued
      push("t6_push0", 8'h21, 8'h01, 3'b001);
      push("t6_push1", 8'h22, 8'h02, 3'b010);
      push("t6_push2", 8'h23, 8'h03, 3'b011);
      chk("t6_running", {31'd0, alu_start}, 32'd1);
      reset = 1'b1;
      tick();
      chk_reset_outputs("t6_reset");
      reset = 1'b0;
      alu_done   = 1'b1;
      alu_result = 16'hBEEF;
      starts = 0;
      rsps   = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (alu_start) starts++;
         if (rsp_valid) rsps++;
      end
      alu_done   = 1'b0;
      alu_result = 16'h0;
      chk("t6_no_start_after_reset", starts, 0);
      chk("t6_no_response_after_reset", rsps, 0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_alu_reset_n", {31'd0, alu_reset_n}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
